// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_pkg;

    typedef enum logic [3:0] {
        StFetch1,
        StFetch2,
        StFetch3,
        StFetch4,
        StDecode,
        StMemAdr,
        StLbRd,
        StLbWr,
        StSbWr,
        StRtypeEx,
        StRtypeWr,
        StBeqEx,
        StJEx,
        StAddiEx,
        StAddiWr
    } state_e;

    localparam logic [5:0] OpLb    = 6'b100000;
    localparam logic [5:0] OpSb    = 6'b101000;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] SrcbReg    = 2'b00;
    localparam logic [1:0] SrcbOne    = 2'b01;
    localparam logic [1:0] SrcbImm    = 2'b10;
    localparam logic [1:0] SrcbBranch = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/mips_controller_if.sv
// Controller <-> datapath signal bundle; the controller is the master.
interface mips_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [1:0] pcsource;
    logic       illegal_op;

    modport master (
        input  op, funct, zero,
        output pcen, memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
        output alusrca, alusrcb, alucont, pcsource, illegal_op
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memread, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
        input  alusrca, alusrcb, alucont, pcsource, illegal_op
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// Maps FSM aluop plus the R-type funct field to the ALU control code.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    always_comb begin
        alucont = AluAdd;
        case (aluop)
            AluOpSub: alucont = AluSub;
            AluOpFunct: begin
                // Unknown funct codes fall back to add rather than trapping.
                case (funct)
                    FunctSub: alucont = AluSub;
                    FunctAnd: alucont = AluAnd;
                    FunctOr:  alucont = AluOr;
                    FunctSlt: alucont = AluSlt;
                    default:  alucont = AluAdd;
                endcase
            end
            default: alucont = AluAdd;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control FSM for the 8-bit MIPS core (byte-wide fetch).
module mips_controller
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mips_controller_if.master ctl
);

    state_e state_q, state_d;

    logic       pcwrite, pcwritecond, aluen;
    logic       memread, memwrite, iord, regdst, memtoreg, regwrite, alusrca, illegal_op;
    logic [3:0] irwrite;
    logic [1:0] alusrcb, pcsource, aluop;
    logic [2:0] alu_dec;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch1;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = StFetch1;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        aluen       = 1'b0;
        aluop       = AluOpAdd;
        memread     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 4'b0000;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SrcbReg;
        pcsource    = PcAlu;
        illegal_op  = 1'b0;

        unique case (state_q)
            StFetch1, StFetch2, StFetch3, StFetch4: begin
                memread = 1'b1;
                alusrcb = SrcbOne;
                aluen   = 1'b1;
                pcwrite = 1'b1;
                unique case (state_q)
                    StFetch1: begin irwrite = 4'b0001; state_d = StFetch2; end
                    StFetch2: begin irwrite = 4'b0010; state_d = StFetch3; end
                    StFetch3: begin irwrite = 4'b0100; state_d = StFetch4; end
                    default:  begin irwrite = 4'b1000; state_d = StDecode; end
                endcase
            end
            StDecode: begin
                alusrcb = SrcbBranch;
                aluen   = 1'b1;
                case (ctl.op)
                    OpLb, OpSb: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpJ:        state_d = StJEx;
                    OpAddi:     state_d = StAddiEx;
                    default:    illegal_op = 1'b1;
                endcase
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = SrcbImm;
                aluen   = 1'b1;
                if (ctl.op == OpLb)      state_d = StLbRd;
                else if (ctl.op == OpSb) state_d = StSbWr;
            end
            StLbRd: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = StLbWr;
            end
            StLbWr: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StSbWr: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                aluen   = 1'b1;
                aluop   = AluOpFunct;
                state_d = StRtypeWr;
            end
            StRtypeWr: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            StBeqEx: begin
                alusrca     = 1'b1;
                aluen       = 1'b1;
                aluop       = AluOpSub;
                pcwritecond = 1'b1;
                pcsource    = PcAluOut;
            end
            StJEx: begin
                pcwrite  = 1'b1;
                pcsource = PcJump;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = SrcbImm;
                aluen   = 1'b1;
                state_d = StAddiWr;
            end
            StAddiWr: regwrite = 1'b1;
            default: ;
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .aluop   (aluop),
        .funct   (ctl.funct),
        .alucont (alu_dec)
    );

    // Reset masks every output in the same cycle so an abandoned instruction writes nothing.
    assign ctl.pcen       = ~reset & (pcwrite | (pcwritecond & ctl.zero));
    assign ctl.memread    = ~reset & memread;
    assign ctl.memwrite   = ~reset & memwrite;
    assign ctl.iord       = ~reset & iord;
    assign ctl.irwrite    = reset ? 4'b0000 : irwrite;
    assign ctl.regdst     = ~reset & regdst;
    assign ctl.memtoreg   = ~reset & memtoreg;
    assign ctl.regwrite   = ~reset & regwrite;
    assign ctl.alusrca    = ~reset & alusrca;
    assign ctl.alusrcb    = reset ? 2'b00 : alusrcb;
    assign ctl.alucont    = (reset || !aluen) ? 3'b000 : alu_dec;
    assign ctl.pcsource   = reset ? 2'b00 : pcsource;
    assign ctl.illegal_op = ~reset & illegal_op;

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the 8-bit MIPS core. It drives every control input of the datapath from the `op`, `funct` and `zero` values the datapath returns. It sequences the four byte-wide instruction fetches, decode, execute, memory access and writeback for LB, SB, R-type, BEQ, J and ADDI. It sits beside the datapath in the CPU top level, and together the two form the complete processor apart from memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- op  in  6  opcode, instr[31:26] from datapath
- funct  in  6  function field, instr[5:0]
- zero  in  1  ALU result == 0
- pcen  out  1  PC register enable
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- irwrite  out  4  one-hot byte enable for the instruction register
- regdst  out  1  0 = rt, 1 = rd as write register
- memtoreg  out  1  0 = ALUOut, 1 = MDR to register file
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = const 1, 10 = imm, 11 = imm (branch offset)
- alucont  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pcsource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
- Moore FSM, 4-bit state register. Outputs decode from state only, except `pcen` and `alucont` in RTYPEEX.
- `pcen = pcwrite | (pcwritecond & zero)`.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000.
- All signals not listed for a state are 0.

States, outputs and transitions:
- FETCH1..FETCH4: memread=1, irwrite=0001/0010/0100/1000, alusrcb=01, alucont=add, pcwrite=1. Transition FETCHn→FETCHn+1; FETCH4→DECODE.
- DECODE: alusrcb=11, alucont=add (precomputes branch target). Transition by op:
  - LB/SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX
  - other → FETCH1 with illegal_op=1
- MEMADR: alusrca=1, alusrcb=10, add. LB → LBRD; SB → SBWR.
- LBRD: memread=1, iord=1. → LBWR.
- LBWR: regwrite=1, memtoreg=1. → FETCH1.
- SBWR: memwrite=1, iord=1. → FETCH1.
- RTYPEEX: alusrca=1, alusrcb=00, alucont from funct. → RTYPEWR.
  - funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct decodes as add; no trap.
- RTYPEWR: regdst=1, regwrite=1. → FETCH1.
- BEQEX: alusrca=1, alusrcb=00, sub, pcwritecond=1, pcsource=01. → FETCH1.
- JEX: pcwrite=1, pcsource=10. → FETCH1.
- ADDIEX: alusrca=1, alusrcb=10, add. → ADDIWR.
- ADDIWR: regwrite=1. → FETCH1.

## Timing
- Reset:
  - While reset=1, all outputs are forced to 0, including pcen and illegal_op.
  - Next state is FETCH1.
  - First cycle after deassertion: FETCH1 outputs (memread=1, irwrite=0001, pcen=1).
- Reset asserted mid-instruction:
  - Outputs are 0 in that same cycle.
  - No partial write is issued.
  - The instruction is abandoned.
- Cycles per instruction, FETCH1 to the next FETCH1: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6.
- BEQ: pcen is sampled combinationally from zero during BEQEX only. With zero=0, pcen=0.
- op and funct must be stable from DECODE through the last state of the instruction; the datapath IR guarantees this.
- irwrite is strictly one-hot in fetch states and 0000 elsewhere.
- memread and memwrite are never high together.

## Structure
- `mips_pkg` holds:
  - state enum
  - opcode and funct localparams
  - alucont encodings
  - alusrcb and pcsource encodings
- Sub-module `mips_alu_decoder`: combinational. Maps a 2-bit aluop (00 add, 01 sub, 10 use funct) plus funct to alucont.
- The FSM supplies aluop per state.

## Test plan
- Reset held 3 cycles, then released:
  - During reset: every output 0.
  - Next cycle: irwrite=0001, memread=1, pcen=1.
  - irwrite then steps 0010, 0100, 1000 on the following cycles.
- op=100000 (LB):
  - LBRD shows iord=1, memread=1.
  - LBWR shows regwrite=1, memtoreg=1, regdst=0.
  - Back in FETCH1 exactly 8 cycles after start.
- op=000000, funct=100010:
  - RTYPEEX shows alucont=110, alusrca=1.
  - RTYPEWR shows regdst=1, regwrite=1.
  - Repeat with funct=101010 → alucont=111.
- op=000100:
  - zero=1 in BEQEX → pcen=1, pcsource=01.
  - zero=0 → pcen=0.
  - Both return to FETCH1 after 6 cycles.
- op=111111:
  - illegal_op pulses for 1 cycle in DECODE.
  - Next state is FETCH1; regwrite and memwrite stay 0 throughout.
- reset asserted during SBWR:
  - memwrite drops to 0 in the same cycle.
  - Following cycle is FETCH1 after reset release.
